scen_trigger_mux: RTL and testbench
===================================

Name: scen_trigger_mux

Overview:
Parametrised successor of the scenario multiplexer. It holds N_SCEN programmable trigger scenarios and drives N_OUT trigger outputs from whichever scenario is selected. Each scenario has its own start delay, period, pulse width, repeat count and output mask. A scenario change made while running takes effect only on a period boundary, so switching never produces glitches. The block sits between the parameter register bus and the output ports of the synchronization block.

Parameters:
N_SCEN, 4, number of scenarios (1..256)
N_OUT, 2, number of trigger output lines
CNT_W, 16, width of the delay/period/width/repeat counters
SEL_W, 8, width of scen_sel

Ports:
clock  in  1  system clock
scen_reset_n  in  1  asynchronous active-low reset
scen_start  in  1  start/retrigger pulse
scen_stop  in  1  stop pulse
scen_sel  in  SEL_W  requested scenario index
cfg_delay  in  N_SCEN*CNT_W  per-scenario start delay (cycles)
cfg_period  in  N_SCEN*CNT_W  per-scenario period (cycles)
cfg_width  in  N_SCEN*CNT_W  per-scenario high time (cycles)
cfg_repeat  in  N_SCEN*CNT_W  periods per burst; 0 = run forever
cfg_out_mask  in  N_SCEN*N_OUT  outputs driven by each scenario
output_trigger  out  N_OUT  registered trigger outputs
active  out  1  high outside IDLE
active_sel  out  SEL_W  scenario currently running
sel_pending  out  1  valid new selection waiting for a boundary
sel_error  out  1  one-cycle pulse: selection index >= N_SCEN
burst_done  out  1  one-cycle pulse: repeat count reached

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; internal counters and latched config cleared.
- States:
  - IDLE: output_trigger = 0.
  - DELAY: counts cfg_delay cycles.
  - RUN: period counter pc runs 0..P-1.
- Config handling:
  - The config of the selected scenario is latched on entry to DELAY/RUN and at each switch.
  - cfg_* inputs may change freely; only latched values are used.
- Effective values:
  - P = max(cfg_period, 2).
  - W = min(cfg_width, P-1), so every period has at least one low cycle.
  - W = 0 gives an output that is always low while timing still runs.
- In RUN: output_trigger <= (pc < W) ? mask : 0, registered.
- Start from IDLE:
  - scen_start sampled at cycle T with scen_sel < N_SCEN: latch config, active_sel <= scen_sel.
  - delay 0: go to RUN, first high cycle at T+1.
  - delay D > 0: go to DELAY, first high cycle at T+1+D.
- Start with invalid selection: scen_start with scen_sel >= N_SCEN pulses sel_error at T+1; the block stays in IDLE.
- Retrigger: scen_start while in DELAY/RUN restarts from the latched start point using the current scen_sel. This includes the delay and clears the repeat counter. Outputs go low on the cycle after the restart if the new delay is nonzero.
- Stop:
  - scen_stop in any state: IDLE next cycle, outputs 0 next cycle.
  - scen_stop and scen_start asserted together: stop wins.
- Period end: at pc == P-1, pc wraps to 0 and the completed-period counter increments.
- Burst end:
  - cfg_repeat = R > 0: after the R-th period ends, burst_done pulses for one cycle and the state goes to IDLE.
  - R = 0: runs until stopped.
  - The repeat counter saturates at its maximum value; it never wraps.
- Selection change while active:
  - scen_sel != active_sel and valid: sel_pending = 1.
  - At the next pc == P-1: latch the new config, active_sel updates, pc = 0, repeat counter cleared, no delay applied.
  - sel_pending clears on that same cycle.
  - If scen_sel returns to active_sel before the boundary, sel_pending drops and no switch occurs.
- Invalid selection while active: the index is ignored; sel_error pulses once per change of scen_sel to an invalid value.
- Selection change in DELAY: does not cut the delay; the switch is taken at the first RUN period boundary.
- Switch and burst end on the same cycle: burst end wins; the block goes to IDLE. A new scen_start is required.
- Outputs: all outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic run. Scenario 0: delay 0, period 10, width 3, repeat 0, mask 2'b01. Pulse start at T.
  - Required: out[0] high for T+1..T+3, low for T+4..T+10, repeating; out[1] stays 0.
- Delay and burst. Scenario 1: delay 5, period 4, width 2, repeat 3, mask 2'b11.
  - Required: first high at T+6; exactly 3 pulses on both lines; burst_done pulses at the end of period 3; active = 0 the next cycle.
- Clamping. period 1 → 2 high-then-low alternation with width 5, i.e. W = 1, P = 2.
  - width 0 → outputs stay 0 while active = 1.
- Glitch-free switch. Running scenario 0 (period 10); set scen_sel = 2 (period 6, width 6) at pc = 4.
  - Required: sel_pending = 1 until pc = 9; scenario-0 timing is unchanged up to then.
  - Required after the boundary: active_sel = 2, output high for 5 cycles then low for 1.
- Errors.
  - scen_sel = 7 with N_SCEN = 4 plus start → sel_error pulse, stays IDLE.
  - Changing scen_sel to 200 while running → one sel_error pulse, no switch.
- Reset and stop.
  - Deassert scen_reset_n mid-high-pulse → all outputs 0 immediately; no pulses after release until a new start.
  - Start and stop in the same cycle → stays IDLE.

Source files
------------

// File: rtl/scen_trigger_mux.sv
// rtl/scen_trigger_mux.sv - N-scenario trigger generator with period-boundary scenario switching
// Config of the chosen scenario is captured into *_q registers; live cfg_* inputs are only read on load.
module scen_trigger_mux #(
  parameter int N_SCEN = 4,
  parameter int N_OUT  = 2,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 8
) (
  input  logic                    clock,
  input  logic                    scen_reset_n,
  input  logic                    scen_start,
  input  logic                    scen_stop,
  input  logic [SEL_W-1:0]        scen_sel,
  input  logic [N_SCEN*CNT_W-1:0] cfg_delay,
  input  logic [N_SCEN*CNT_W-1:0] cfg_period,
  input  logic [N_SCEN*CNT_W-1:0] cfg_width,
  input  logic [N_SCEN*CNT_W-1:0] cfg_repeat,
  input  logic [N_SCEN*N_OUT-1:0] cfg_out_mask,
  output logic [N_OUT-1:0]        output_trigger,
  output logic                    active,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    sel_pending,
  output logic                    sel_error,
  output logic                    burst_done
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   r_q, r_d;
  logic [N_OUT-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   active_sel_q, active_sel_d;
  logic [SEL_W-1:0]   sel_prev_q, sel_prev_d;
  logic [N_OUT-1:0]   trig_q, trig_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               sel_valid;
  logic [SEL_W-1:0]   cfg_idx;
  logic [CNT_W-1:0]   ld_delay, ld_period, ld_width, ld_repeat;
  logic [N_OUT-1:0]   ld_mask;
  logic [CNT_W-1:0]   ld_p, ld_w;
  logic [CNT_W-1:0]   pc_inc, rcnt_inc;
  logic               period_end;
  logic               load;

  assign sel_valid = (32'(scen_sel) < 32'(N_SCEN));
  // An invalid request never replaces the running scenario; reload the current one instead.
  assign cfg_idx   = sel_valid ? scen_sel : active_sel_q;

  always_comb begin
    ld_delay  = '0;
    ld_period = '0;
    ld_width  = '0;
    ld_repeat = '0;
    ld_mask   = '0;
    for (int i = 0; i < N_SCEN; i++) begin
      if (cfg_idx == SEL_W'(i)) begin
        ld_delay  = cfg_delay[i*CNT_W +: CNT_W];
        ld_period = cfg_period[i*CNT_W +: CNT_W];
        ld_width  = cfg_width[i*CNT_W +: CNT_W];
        ld_repeat = cfg_repeat[i*CNT_W +: CNT_W];
        ld_mask   = cfg_out_mask[i*N_OUT +: N_OUT];
      end
    end
  end

  assign ld_p       = (ld_period < CNT_W'(2)) ? CNT_W'(2) : ld_period;
  assign ld_w       = (ld_width > ld_p - CNT_W'(1)) ? ld_p - CNT_W'(1) : ld_width;
  assign pc_inc     = pc_q + CNT_W'(1);
  assign rcnt_inc   = (rcnt_q == '1) ? rcnt_q : rcnt_q + CNT_W'(1);
  assign period_end = (state_q == RUN) && (pc_q == p_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dcnt_d       = dcnt_q;
    rcnt_d       = rcnt_q;
    active_sel_d = active_sel_q;
    sel_prev_d   = scen_sel;
    trig_d       = '0;
    err_d        = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;

    if (scen_stop) begin
      state_d = IDLE;
    end else if (scen_start && (state_q == IDLE) && !sel_valid) begin
      err_d = 1'b1;
    end else if (scen_start) begin
      load         = 1'b1;
      active_sel_d = cfg_idx;
      rcnt_d       = '0;
      pc_d         = '0;
      if (ld_delay == '0) begin
        state_d = RUN;
        trig_d  = (ld_w != '0) ? ld_mask : '0;
      end else begin
        state_d = DELAY;
        dcnt_d  = ld_delay;
      end
    end else begin
      case (state_q)
        DELAY: begin
          if (dcnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            pc_d    = '0;
            trig_d  = (w_q != '0) ? mask_q : '0;
          end else begin
            dcnt_d = dcnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (period_end) begin
            rcnt_d = rcnt_inc;
            pc_d   = '0;
            if ((r_q != '0) && (rcnt_inc == r_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (sel_valid && (scen_sel != active_sel_q)) begin
              load         = 1'b1;
              active_sel_d = scen_sel;
              rcnt_d       = '0;
              trig_d       = (ld_w != '0) ? ld_mask : '0;
            end else begin
              trig_d = (w_q != '0) ? mask_q : '0;
            end
          end else begin
            pc_d   = pc_inc;
            trig_d = (pc_inc < w_q) ? mask_q : '0;
          end
        end
        default: ;
      endcase
    end

    // Report each fresh move of the selector onto an out-of-range index while running.
    if ((state_q != IDLE) && !sel_valid && (scen_sel != sel_prev_q)) begin
      err_d = 1'b1;
    end

    pending_d = (state_d != IDLE) && sel_valid && (scen_sel != active_sel_d);
  end

  assign p_d    = load ? ld_p : p_q;
  assign w_d    = load ? ld_w : w_q;
  assign r_d    = load ? ld_repeat : r_q;
  assign mask_d = load ? ld_mask : mask_q;

  always_ff @(posedge clock or negedge scen_reset_n) begin
    if (!scen_reset_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      dcnt_q       <= '0;
      rcnt_q       <= '0;
      p_q          <= '0;
      w_q          <= '0;
      r_q          <= '0;
      mask_q       <= '0;
      active_sel_q <= '0;
      sel_prev_q   <= '0;
      trig_q       <= '0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dcnt_q       <= dcnt_d;
      rcnt_q       <= rcnt_d;
      p_q          <= p_d;
      w_q          <= w_d;
      r_q          <= r_d;
      mask_q       <= mask_d;
      active_sel_q <= active_sel_d;
      sel_prev_q   <= sel_prev_d;
      trig_q       <= trig_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign output_trigger = trig_q;
  assign active         = (state_q != IDLE);
  assign active_sel     = active_sel_q;
  assign sel_pending    = pending_q;
  assign sel_error      = err_q;
  assign burst_done     = done_q;

endmodule

// File: tb/tb_scen_trigger_mux.sv
// tb/tb_scen_trigger_mux.sv - directed and randomized checks of scen_trigger_mux
// Expected waveforms come from elapsed-cycle arithmetic on each scenario's delay/period/width/repeat.
module tb_scen_trigger_mux;

  localparam int N_SCEN = 4;
  localparam int N_OUT  = 2;
  localparam int CNT_W  = 16;
  localparam int SEL_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    stop;
  logic [SEL_W-1:0]        sel;
  logic [N_SCEN*CNT_W-1:0] cfg_delay;
  logic [N_SCEN*CNT_W-1:0] cfg_period;
  logic [N_SCEN*CNT_W-1:0] cfg_width;
  logic [N_SCEN*CNT_W-1:0] cfg_repeat;
  logic [N_SCEN*N_OUT-1:0] cfg_mask;
  logic [N_OUT-1:0]        trig;
  logic                    active;
  logic [SEL_W-1:0]        active_sel;
  logic                    sel_pending;
  logic                    sel_error;
  logic                    burst_done;

  int n_chk  = 0;
  int n_fail = 0;

  scen_trigger_mux #(
    .N_SCEN(N_SCEN), .N_OUT(N_OUT), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clock          (clk),
    .scen_reset_n   (rst_n),
    .scen_start     (start),
    .scen_stop      (stop),
    .scen_sel       (sel),
    .cfg_delay      (cfg_delay),
    .cfg_period     (cfg_period),
    .cfg_width      (cfg_width),
    .cfg_repeat     (cfg_repeat),
    .cfg_out_mask   (cfg_mask),
    .output_trigger (trig),
    .active         (active),
    .active_sel     (active_sel),
    .sel_pending    (sel_pending),
    .sel_error      (sel_error),
    .burst_done     (burst_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_scen(input int idx, input int d, input int p, input int w, input int r,
                          input logic [N_OUT-1:0] m);
    cfg_delay[idx*CNT_W +: CNT_W]  = CNT_W'(d);
    cfg_period[idx*CNT_W +: CNT_W] = CNT_W'(p);
    cfg_width[idx*CNT_W +: CNT_W]  = CNT_W'(w);
    cfg_repeat[idx*CNT_W +: CNT_W] = CNT_W'(r);
    cfg_mask[idx*N_OUT +: N_OUT]   = m;
  endtask

  task automatic pulse_start(input int s);
    sel   = SEL_W'(s);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk({tag, ".stop_active"}, 32'(active), 32'd0);
    chk({tag, ".stop_trig"}, 32'(trig), 32'd0);
  endtask

  // Cycle c counts from the first cycle after the start edge (c = 1).
  task automatic expect_run(input string tag, input int d, input int p, input int w, input int r,
                            input logic [N_OUT-1:0] m, input int asel, input int c0, input int c1);
    int pe, we, t;
    logic [N_OUT-1:0] et;
    logic ea, ed;
    pe = (p < 2) ? 2 : p;
    we = (w > pe - 1) ? pe - 1 : w;
    for (int c = c0; c <= c1; c++) begin
      t = c - 1 - d;
      if (c <= d) begin
        et = '0; ea = 1'b1; ed = 1'b0;
      end else if (r > 0 && t >= r * pe) begin
        et = '0; ea = 1'b0; ed = (t == r * pe);
      end else begin
        et = ((t % pe) < we) ? m : '0; ea = 1'b1; ed = 1'b0;
      end
      chk($sformatf("%s.trig@%0d", tag, c), 32'(trig), 32'(et));
      chk($sformatf("%s.active@%0d", tag, c), 32'(active), 32'(ea));
      chk($sformatf("%s.done@%0d", tag, c), 32'(burst_done), 32'(ed));
      chk($sformatf("%s.pending@%0d", tag, c), 32'(sel_pending), 32'd0);
      chk($sformatf("%s.err@%0d", tag, c), 32'(sel_error), 32'd0);
      if (ea) chk($sformatf("%s.asel@%0d", tag, c), 32'(active_sel), 32'(asel));
      step();
    end
  endtask

  initial begin
    int d, p, w, r, s, pe, c1;
    logic [N_OUT-1:0] m;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sel = '0;
    cfg_delay = '0; cfg_period = '0; cfg_width = '0; cfg_repeat = '0; cfg_mask = '0;
    set_scen(0, 0, 10, 3, 0, 2'b01);
    set_scen(1, 5, 4, 2, 3, 2'b11);
    set_scen(2, 0, 6, 6, 0, 2'b10);
    set_scen(3, 0, 1, 5, 0, 2'b11);
    repeat (3) step();
    chk("rst.trig", 32'(trig), 32'd0);
    chk("rst.active", 32'(active), 32'd0);
    chk("rst.asel", 32'(active_sel), 32'd0);
    chk("rst.pending", 32'(sel_pending), 32'd0);
    chk("rst.err", 32'(sel_error), 32'd0);
    chk("rst.done", 32'(burst_done), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic free-running scenario 0.
    pulse_start(0);
    expect_run("basic", 0, 10, 3, 0, 2'b01, 0, 1, 25);
    do_stop("basic");

    // Delayed burst of three periods.
    pulse_start(1);
    expect_run("burst", 5, 4, 2, 3, 2'b11, 1, 1, 22);

    // Clamped period and zero width.
    pulse_start(3);
    expect_run("clampP", 0, 1, 5, 0, 2'b11, 3, 1, 8);
    do_stop("clampP");
    set_scen(3, 0, 1, 0, 0, 2'b11);
    pulse_start(3);
    expect_run("zeroW", 0, 1, 0, 0, 2'b11, 3, 1, 6);
    do_stop("zeroW");

    // Switch 0 -> 2 requested at pc = 4, taken at the period boundary.
    pulse_start(0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("sw.trig@%0d", c), 32'(trig), ((c - 1) % 10 < 3) ? 32'd1 : 32'd0);
      chk($sformatf("sw.pending@%0d", c), 32'(sel_pending), (c >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("sw.asel@%0d", c), 32'(active_sel), 32'd0);
      if (c == 5) sel = 8'd2;
      step();
    end
    expect_run("sw_new", 0, 6, 6, 0, 2'b10, 2, 1, 13);
    do_stop("sw");

    // Invalid start from IDLE.
    pulse_start(7);
    chk("badstart.err", 32'(sel_error), 32'd1);
    chk("badstart.active", 32'(active), 32'd0);
    step();
    chk("badstart.err2", 32'(sel_error), 32'd0);
    chk("badstart.active2", 32'(active), 32'd0);

    // Invalid selection while running: single error pulse, no switch.
    pulse_start(0);
    sel = 8'd200;
    step();
    chk("badsel.err", 32'(sel_error), 32'd1);
    step();
    expect_run("badsel", 0, 10, 3, 0, 2'b01, 0, 3, 25);
    do_stop("badsel");
    sel = 8'd0;

    // Retrigger onto scenario 1 while running scenario 0.
    pulse_start(0);
    expect_run("retrig_pre", 0, 10, 3, 0, 2'b01, 0, 1, 4);
    pulse_start(1);
    expect_run("retrig", 5, 4, 2, 3, 2'b11, 1, 1, 20);

    // Asynchronous reset in the middle of a high pulse.
    pulse_start(0);
    chk("arst.pre", 32'(trig), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.trig", 32'(trig), 32'd0);
    chk("arst.active", 32'(active), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      chk($sformatf("arst.quiet@%0d", c), 32'({active, trig}), 32'd0);
    end

    // Start and stop together: stop wins.
    sel = 8'd0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("startstop.active", 32'(active), 32'd0);
    chk("startstop.trig", 32'(trig), 32'd0);
    step();
    chk("startstop.active2", 32'(active), 32'd0);

    // Randomized scenarios; config inputs are scrambled after the start edge.
    for (int it = 0; it < 20; it++) begin
      s = int'($urandom_range(0, N_SCEN - 1));
      d = int'($urandom_range(0, 6));
      p = int'($urandom_range(0, 8));
      w = int'($urandom_range(0, 9));
      r = int'($urandom_range(0, 4));
      m = N_OUT'($urandom_range(0, 3));
      set_scen(s, d, p, w, r, m);
      pulse_start(s);
      set_scen(s, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               N_OUT'($urandom_range(0, 3)));
      pe = (p < 2) ? 2 : p;
      c1 = d + ((r > 0) ? r * pe + 2 : 2 * pe + 3);
      expect_run($sformatf("rnd%0d", it), d, p, w, r, m, s, 1, c1);
      do_stop($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
